// File: rtl/powerup_ctrl.sv
// Power-up controller: one-slot pickup inventory, key-triggered activation,
// and frame-timed speed-boost / wall-phase windows with an embedded-in-wall grace.
module powerup_ctrl #(
  parameter int          SPEED_FRAMES    = 300,
  parameter int          PHASE_FRAMES    = 180,
  parameter int          GRACE_MAX       = 120,
  parameter int          COOLDOWN_FRAMES = 60,
  parameter logic [7:0]  ACT_KEY         = 8'h2C
) (
  input  logic       frame_clk,
  input  logic       Reset_n,
  input  logic [7:0] keycode,
  input  logic       pickup_valid,
  input  logic [1:0] pickup_type,
  input  logic       onWall,
  output logic       speedBoost_active,
  output logic       wallPhase_active,
  output logic [1:0] held_type,
  output logic       pickup_ack,
  output logic       force_respawn,
  output logic [2:0] state,
  output logic [9:0] frames_left
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] SPEED    = 3'd1;
  localparam logic [2:0] PHASE    = 3'd2;
  localparam logic [2:0] GRACE    = 3'd3;
  localparam logic [2:0] COOLDOWN = 3'd4;

  localparam logic [1:0] TYPE_NONE  = 2'b00;
  localparam logic [1:0] TYPE_SPEED = 2'b01;
  localparam logic [1:0] TYPE_PHASE = 2'b10;

  localparam logic [9:0] SPEED_LOAD    = 10'(SPEED_FRAMES);
  localparam logic [9:0] PHASE_LOAD    = 10'(PHASE_FRAMES);
  localparam logic [9:0] GRACE_LOAD    = 10'(GRACE_MAX);
  localparam logic [9:0] COOLDOWN_LOAD = 10'(COOLDOWN_FRAMES);

  logic       act_key_now;
  logic       prev_act;
  logic       act_edge;
  logic       activate;
  logic       type_valid;
  logic       pickup_ok;
  logic       expiring;
  logic [9:0] frames_dec;

  logic [2:0] next_state;
  logic [9:0] next_frames;
  logic [1:0] next_held;
  logic       next_respawn;

  assign act_key_now = (keycode == ACT_KEY);
  assign act_edge    = act_key_now && !prev_act;

  // Activation only happens from IDLE with something in the slot.
  assign activate    = (state == IDLE) && act_edge && (held_type != TYPE_NONE);

  // A pickup may refill the slot in the same frame the old contents are consumed.
  assign type_valid  = (pickup_type == TYPE_SPEED) || (pickup_type == TYPE_PHASE);
  assign pickup_ok   = pickup_valid && type_valid &&
                       ((held_type == TYPE_NONE) || activate);

  // Treating 0 as expiry too keeps the counter from ever wrapping.
  assign expiring    = (frames_left <= 10'd1);
  assign frames_dec  = frames_left - 10'd1;

  always_comb begin
    next_state   = state;
    next_frames  = frames_left;
    next_respawn = 1'b0;
    case (state)
      IDLE: begin
        next_frames = 10'd0;
        if (activate) begin
          if (held_type == TYPE_SPEED) begin
            next_state  = SPEED;
            next_frames = SPEED_LOAD;
          end else begin
            next_state  = PHASE;
            next_frames = PHASE_LOAD;
          end
        end
      end
      SPEED: begin
        if (expiring) begin
          next_state  = COOLDOWN;
          next_frames = COOLDOWN_LOAD;
        end else begin
          next_frames = frames_dec;
        end
      end
      PHASE: begin
        if (expiring) begin
          if (onWall) begin
            next_state  = GRACE;
            next_frames = GRACE_LOAD;
          end else begin
            next_state  = COOLDOWN;
            next_frames = COOLDOWN_LOAD;
          end
        end else begin
          next_frames = frames_dec;
        end
      end
      GRACE: begin
        // Leaving the wall ends grace immediately, even on the final frame.
        if (!onWall) begin
          next_state  = COOLDOWN;
          next_frames = COOLDOWN_LOAD;
        end else if (expiring) begin
          next_state   = COOLDOWN;
          next_frames  = COOLDOWN_LOAD;
          next_respawn = 1'b1;
        end else begin
          next_frames = frames_dec;
        end
      end
      COOLDOWN: begin
        if (expiring) begin
          next_state  = IDLE;
          next_frames = 10'd0;
        end else begin
          next_frames = frames_dec;
        end
      end
      default: begin
        next_state  = IDLE;
        next_frames = 10'd0;
      end
    endcase
  end

  always_comb begin
    next_held = held_type;
    if (pickup_ok) begin
      next_held = pickup_type;
    end else if (activate) begin
      next_held = TYPE_NONE;
    end
  end

  // Outputs are registered from next-state values so they line up with state.
  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state             <= IDLE;
      frames_left       <= 10'd0;
      held_type         <= TYPE_NONE;
      pickup_ack        <= 1'b0;
      force_respawn     <= 1'b0;
      speedBoost_active <= 1'b0;
      wallPhase_active  <= 1'b0;
      prev_act          <= 1'b0;
    end else begin
      state             <= next_state;
      frames_left       <= next_frames;
      held_type         <= next_held;
      pickup_ack        <= pickup_ok;
      force_respawn     <= next_respawn;
      speedBoost_active <= (next_state == SPEED);
      wallPhase_active  <= (next_state == PHASE) || (next_state == GRACE);
      prev_act          <= act_key_now;
    end
  end

endmodule

// File: tb/tb_powerup_ctrl.sv
// Directed self-checking bench for powerup_ctrl: inventory, activation timing,
// grace/respawn behaviour, ignored keys and asynchronous reset.
module tb_powerup_ctrl;

  localparam logic [7:0] KEY = 8'h2C;
  localparam logic [2:0] S_IDLE = 3'd0, S_SPEED = 3'd1, S_PHASE = 3'd2,
                         S_GRACE = 3'd3, S_COOL = 3'd4;

  logic       frame_clk;
  logic       Reset_n;
  logic [7:0] keycode;
  logic       pickup_valid;
  logic [1:0] pickup_type;
  logic       onWall;
  logic       speedBoost_active;
  logic       wallPhase_active;
  logic [1:0] held_type;
  logic       pickup_ack;
  logic       force_respawn;
  logic [2:0] state;
  logic [9:0] frames_left;

  int checks = 0;
  int errors = 0;
  int cnt;
  int pulses;
  logic seen;

  powerup_ctrl dut (
    .frame_clk(frame_clk),
    .Reset_n(Reset_n),
    .keycode(keycode),
    .pickup_valid(pickup_valid),
    .pickup_type(pickup_type),
    .onWall(onWall),
    .speedBoost_active(speedBoost_active),
    .wallPhase_active(wallPhase_active),
    .held_type(held_type),
    .pickup_ack(pickup_ack),
    .force_respawn(force_respawn),
    .state(state),
    .frames_left(frames_left)
  );

  initial begin
    frame_clk = 1'b0;
    forever #5 frame_clk = ~frame_clk;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish (observed timeout, expected completion)");
    $fatal(1, "[TB] watchdog expired");
  end

  // Drive one frame of inputs, then land on the following falling edge.
  task automatic applyStimulus(input logic [7:0] key, input logic pv,
                               input logic [1:0] ptype, input logic wall);
    keycode      = key;
    pickup_valid = pv;
    pickup_type  = ptype;
    onWall       = wall;
    @(posedge frame_clk);
    @(negedge frame_clk);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $display("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
      $error("[TB] check %s did not match", tag);
    end
  endtask

  task automatic waitIdle(input string tag);
    for (int i = 0; i < 2000; i++) begin
      if (state == S_IDLE) break;
      applyStimulus(8'h00, 1'b0, 2'b00, 1'b0);
    end
    checkOutput(tag, 32'(state), 32'(S_IDLE));
  endtask

  initial begin
    keycode = 8'h00; pickup_valid = 1'b0; pickup_type = 2'b00; onWall = 1'b0;
    Reset_n = 1'b1;
    #2 Reset_n = 1'b0;
    #1;
    checkOutput("rst_state", 32'(state), 32'(S_IDLE));
    checkOutput("rst_frames", 32'(frames_left), 0);
    checkOutput("rst_held", 32'(held_type), 0);
    checkOutput("rst_speed", 32'(speedBoost_active), 0);
    checkOutput("rst_phase", 32'(wallPhase_active), 0);
    checkOutput("rst_ack", 32'(pickup_ack), 0);
    checkOutput("rst_respawn", 32'(force_respawn), 0);
    @(negedge frame_clk);
    Reset_n = 1'b1;
    applyStimulus(8'h00, 1'b0, 2'b00, 1'b0);
    checkOutput("idle_after_reset", 32'(state), 32'(S_IDLE));

    // Speed pickup, key held 5 frames, speed window then cooldown
    applyStimulus(8'h00, 1'b1, 2'b01, 1'b0);
    checkOutput("t1_ack", 32'(pickup_ack), 1);
    checkOutput("t1_held", 32'(held_type), 1);
    applyStimulus(8'h00, 1'b0, 2'b00, 1'b0);
    checkOutput("t1_ack_drop", 32'(pickup_ack), 0);
    applyStimulus(KEY, 1'b0, 2'b00, 1'b0);
    checkOutput("t1_state_speed", 32'(state), 32'(S_SPEED));
    checkOutput("t1_speed_on", 32'(speedBoost_active), 1);
    checkOutput("t1_frames_load", 32'(frames_left), 300);
    checkOutput("t1_held_clear", 32'(held_type), 0);
    cnt = 1;
    repeat (4) begin
      applyStimulus(KEY, 1'b0, 2'b00, 1'b0);
      if (speedBoost_active) cnt++;
    end
    checkOutput("t1_held_key_once", 32'(frames_left), 296);
    for (int i = 0; i < 1000; i++) begin
      applyStimulus(8'h00, 1'b0, 2'b00, 1'b0);
      if (speedBoost_active) cnt++; else break;
    end
    checkOutput("t1_speed_len", cnt, 300);
    checkOutput("t1_cool_state", 32'(state), 32'(S_COOL));
    checkOutput("t1_cool_load", 32'(frames_left), 60);
    cnt = 1;
    for (int i = 0; i < 1000; i++) begin
      applyStimulus(8'h00, 1'b0, 2'b00, 1'b0);
      if (state == S_COOL) cnt++; else break;
    end
    checkOutput("t1_cool_len", cnt, 60);
    checkOutput("t1_idle", 32'(state), 32'(S_IDLE));
    checkOutput("t1_idle_frames", 32'(frames_left), 0);

    // Phase, off the wall at expiry
    applyStimulus(8'h00, 1'b1, 2'b10, 1'b0);
    checkOutput("t2_ack", 32'(pickup_ack), 1);
    checkOutput("t2_held", 32'(held_type), 2);
    applyStimulus(KEY, 1'b0, 2'b00, 1'b0);
    checkOutput("t2_state_phase", 32'(state), 32'(S_PHASE));
    checkOutput("t2_phase_on", 32'(wallPhase_active), 1);
    checkOutput("t2_frames_load", 32'(frames_left), 180);
    cnt = 1; seen = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      applyStimulus(8'h00, 1'b0, 2'b00, 1'b0);
      seen |= force_respawn;
      if (wallPhase_active) cnt++; else break;
    end
    checkOutput("t2_phase_len", cnt, 180);
    checkOutput("t2_cool_state", 32'(state), 32'(S_COOL));
    checkOutput("t2_no_respawn", 32'(seen), 0);
    waitIdle("t2_back_idle");

    // Phase on the wall at expiry, leave after 40 grace frames
    applyStimulus(8'h00, 1'b1, 2'b10, 1'b0);
    applyStimulus(KEY, 1'b0, 2'b00, 1'b1);
    cnt = 1; seen = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      applyStimulus(8'h00, 1'b0, 2'b00, 1'b1);
      seen |= force_respawn;
      if (wallPhase_active) cnt++;
      if (state != S_PHASE) break;
    end
    checkOutput("t3_grace_state", 32'(state), 32'(S_GRACE));
    checkOutput("t3_grace_load", 32'(frames_left), 120);
    checkOutput("t3_len_at_grace", cnt, 181);
    repeat (39) begin
      applyStimulus(8'h00, 1'b0, 2'b00, 1'b1);
      seen |= force_respawn;
      if (wallPhase_active) cnt++;
    end
    checkOutput("t3_grace_frames", 32'(frames_left), 81);
    applyStimulus(8'h00, 1'b0, 2'b00, 1'b0);
    seen |= force_respawn;
    if (wallPhase_active) cnt++;
    checkOutput("t3_cool_state", 32'(state), 32'(S_COOL));
    checkOutput("t3_phase_off", 32'(wallPhase_active), 0);
    checkOutput("t3_total_len", cnt, 220);
    checkOutput("t3_no_respawn", 32'(seen), 0);
    waitIdle("t3_back_idle");

    // Phase with onWall held: grace expires and requests a respawn
    applyStimulus(8'h00, 1'b1, 2'b10, 1'b1);
    applyStimulus(KEY, 1'b0, 2'b00, 1'b1);
    for (int i = 0; i < 1000; i++) begin
      if (state != S_PHASE) break;
      applyStimulus(8'h00, 1'b0, 2'b00, 1'b1);
    end
    cnt = 1; pulses = 0;
    for (int i = 0; i < 1000; i++) begin
      applyStimulus(8'h00, 1'b0, 2'b00, 1'b1);
      if (force_respawn) pulses++;
      if (state == S_GRACE) cnt++; else break;
    end
    checkOutput("t4_grace_len", cnt, 120);
    checkOutput("t4_cool_state", 32'(state), 32'(S_COOL));
    checkOutput("t4_respawn_on", 32'(force_respawn), 1);
    checkOutput("t4_phase_off", 32'(wallPhase_active), 0);
    applyStimulus(8'h00, 1'b0, 2'b00, 1'b1);
    if (force_respawn) pulses++;
    checkOutput("t4_respawn_drop", 32'(force_respawn), 0);
    checkOutput("t4_respawn_once", pulses, 1);
    waitIdle("t4_back_idle");

    // Inventory corner cases and same-cycle activation + pickup
    applyStimulus(8'h00, 1'b1, 2'b11, 1'b0);
    checkOutput("t5_invalid_ack", 32'(pickup_ack), 0);
    checkOutput("t5_invalid_held", 32'(held_type), 0);
    applyStimulus(KEY, 1'b0, 2'b00, 1'b0);
    checkOutput("t5_empty_act", 32'(state), 32'(S_IDLE));
    applyStimulus(8'h00, 1'b1, 2'b01, 1'b0);
    checkOutput("t5_fill_ack", 32'(pickup_ack), 1);
    applyStimulus(8'h00, 1'b1, 2'b10, 1'b0);
    checkOutput("t5_full_ack", 32'(pickup_ack), 0);
    checkOutput("t5_full_held", 32'(held_type), 1);
    applyStimulus(KEY, 1'b1, 2'b10, 1'b0);
    checkOutput("t5_same_state", 32'(state), 32'(S_SPEED));
    checkOutput("t5_same_held", 32'(held_type), 2);
    checkOutput("t5_same_ack", 32'(pickup_ack), 1);
    repeat (150) applyStimulus(8'h00, 1'b0, 2'b00, 1'b0);
    checkOutput("t5_mid_frames", 32'(frames_left), 150);

    // Asynchronous reset mid-SPEED, checked before the next rising edge
    #1 Reset_n = 1'b0;
    #1;
    checkOutput("t6_rst_state", 32'(state), 32'(S_IDLE));
    checkOutput("t6_rst_speed", 32'(speedBoost_active), 0);
    checkOutput("t6_rst_held", 32'(held_type), 0);
    checkOutput("t6_rst_frames", 32'(frames_left), 0);
    @(negedge frame_clk);
    Reset_n = 1'b1;
    applyStimulus(8'h00, 1'b0, 2'b00, 1'b0);
    checkOutput("t6_idle_after", 32'(state), 32'(S_IDLE));

    // Key during COOLDOWN is ignored
    applyStimulus(8'h00, 1'b1, 2'b01, 1'b0);
    applyStimulus(KEY, 1'b0, 2'b00, 1'b0);
    checkOutput("t7_speed", 32'(state), 32'(S_SPEED));
    applyStimulus(8'h00, 1'b1, 2'b01, 1'b0);
    for (int i = 0; i < 1000; i++) begin
      if (state != S_SPEED) break;
      applyStimulus(8'h00, 1'b0, 2'b00, 1'b0);
    end
    checkOutput("t7_cool_state", 32'(state), 32'(S_COOL));
    applyStimulus(KEY, 1'b0, 2'b00, 1'b0);
    checkOutput("t7_key_ignored", 32'(state), 32'(S_COOL));
    checkOutput("t7_held_kept", 32'(held_type), 1);
    waitIdle("t7_back_idle");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
